// File: rtl/goal_referee.sv
// Goal referee: detects goals from ball position, keeps score, times the
// post-goal centring hold and declares the winner of the match.
module goal_referee #(
    parameter int GOAL_X_LEFT  = 22,
    parameter int GOAL_X_RIGHT = 617,
    parameter int GOAL_Y_TOP   = 200,
    parameter int GOAL_Y_BOT   = 280,
    parameter int HOLD_FRAMES  = 120,
    parameter int WIN_SCORE    = 5
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] BallS,
    input  logic       startGame,
    output logic       centerBall,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       goalPulse,
    output logic       gameOver,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [10:0] X_LEFT    = 11'(GOAL_X_LEFT);
    localparam logic [10:0] X_RIGHT   = 11'(GOAL_X_RIGHT);
    localparam logic [9:0]  Y_TOP     = 10'(GOAL_Y_TOP);
    localparam logic [9:0]  Y_BOT     = 10'(GOAL_Y_BOT);
    localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_FRAMES - 1);
    localparam logic [3:0]  WIN       = 4'(WIN_SCORE);

    state_t      state;
    logic [7:0]  hold_cnt;
    logic        in_mouth;
    logic        left_goal;
    logic        right_goal;
    logic [3:0]  score1_inc;
    logic [3:0]  score2_inc;

    // Edges are compared at 11 bits so a ball near either border cannot wrap.
    assign in_mouth   = (BallY >= Y_TOP) && (BallY <= Y_BOT);
    assign left_goal  = in_mouth && ({1'b0, BallX} <= X_LEFT + {1'b0, BallS});
    assign right_goal = in_mouth && (({1'b0, BallX} + {1'b0, BallS}) >= X_RIGHT);
    assign score1_inc = score1 + 4'd1;
    assign score2_inc = score2 + 4'd1;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= PLAY;
            hold_cnt   <= 8'd0;
            score1     <= 4'd0;
            score2     <= 4'd0;
            centerBall <= 1'b0;
            goalPulse  <= 1'b0;
            gameOver   <= 1'b0;
            winner     <= 2'b00;
        end else begin
            goalPulse <= 1'b0;
            if (startGame) begin
                state      <= HOLD;
                hold_cnt   <= HOLD_LOAD;
                score1     <= 4'd0;
                score2     <= 4'd0;
                centerBall <= 1'b1;
                gameOver   <= 1'b0;
                winner     <= 2'b00;
            end else begin
                case (state)
                    PLAY: begin
                        // A ball touching both goal lines is ambiguous and ignored.
                        if (left_goal != right_goal) begin
                            goalPulse  <= 1'b1;
                            centerBall <= 1'b1;
                            if (left_goal) begin
                                score2 <= score2_inc;
                                if (score2_inc == WIN) begin
                                    state    <= OVER;
                                    gameOver <= 1'b1;
                                    winner   <= 2'b10;
                                end else begin
                                    state    <= HOLD;
                                    hold_cnt <= HOLD_LOAD;
                                end
                            end else begin
                                score1 <= score1_inc;
                                if (score1_inc == WIN) begin
                                    state    <= OVER;
                                    gameOver <= 1'b1;
                                    winner   <= 2'b01;
                                end else begin
                                    state    <= HOLD;
                                    hold_cnt <= HOLD_LOAD;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == 8'd0) begin
                            state      <= PLAY;
                            centerBall <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                    OVER: begin
                        state <= OVER;
                    end
                    default: begin
                        state <= PLAY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_goal_referee.sv
// Directed bench for goal_referee: expected output snapshots are queued as
// stimulus is driven and compared once the DUT has clocked them.
module tb_goal_referee;

    logic       frame_clk;
    logic       Reset;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallS;
    logic       startGame;
    logic       centerBall;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       goalPulse;
    logic       gameOver;
    logic [1:0] winner;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [12:0] val;  // {score1, score2, centerBall, goalPulse, gameOver, winner}
    } exp_t;

    exp_t sb_q[$];

    goal_referee dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .BallX     (BallX),
        .BallY     (BallY),
        .BallS     (BallS),
        .startGame (startGame),
        .centerBall(centerBall),
        .score1    (score1),
        .score2    (score2),
        .goalPulse (goalPulse),
        .gameOver  (gameOver),
        .winner    (winner)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic ball(input int x, input int y, input int s);
        BallX = 10'(x);
        BallY = 10'(y);
        BallS = 10'(s);
    endtask

    task automatic push(input string tag, input int s1, input int s2, input logic cb,
                        input logic gp, input logic go, input logic [1:0] win);
        exp_t e;
        e.tag = tag;
        e.val = {4'(s1), 4'(s2), cb, gp, go, win};
        sb_q.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [12:0] obs;
        e   = sb_q.pop_front();
        obs = {score1, score2, centerBall, goalPulse, gameOver, winner};
        n_vec++;
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: got s1=%0d s2=%0d cb=%b gp=%b go=%b win=%b, need s1=%0d s2=%0d cb=%b gp=%b go=%b win=%b",
                   e.tag, obs[12:9], obs[8:5], obs[4], obs[3], obs[2], obs[1:0],
                   e.val[12:9], e.val[8:5], e.val[4], e.val[3], e.val[2], e.val[1:0]);
        end
        $display("vector %0d %s: s1=%0d s2=%0d cb=%b gp=%b go=%b win=%b",
                 n_vec, e.tag, score1, score2, centerBall, goalPulse, gameOver, winner);
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0d, need %0d", tag, obs, expv);
        end
        $display("vector %0d %s: got %0d", n_vec, tag, obs);
    endtask

    // Counts cycles with centerBall high, starting from the current sample.
    task automatic measure_hold(output int high, output int pulses);
        high   = 0;
        pulses = 0;
        while (centerBall === 1'b1 && high < 400) begin
            high++;
            step();
            if (goalPulse !== 1'b0) pulses++;
        end
    endtask

    initial begin
        int hi;
        int gp_cnt;
        int bad;

        Reset     = 1'b1;
        startGame = 1'b0;
        ball(320, 240, 4);
        #2;
        push("reset_state", 0, 0, 0, 0, 0, 2'b00);
        check();
        #1 Reset = 1'b0;

        // Left goal right after reset release
        ball(18, 240, 4);
        push("left_goal_first", 0, 1, 1, 1, 0, 2'b00);
        step();
        check();
        ball(320, 240, 4);
        push("pulse_one_cycle", 0, 1, 1, 0, 0, 2'b00);
        step();
        check();
        measure_hold(hi, gp_cnt);
        check_int("hold_len_goal", hi + 1, 120);
        check_int("no_pulse_in_hold", gp_cnt, 0);

        // Ball parked in the right goal: one count per PLAY visit only
        ball(614, 240, 4);
        push("right_goal", 1, 1, 1, 1, 0, 2'b00);
        step();
        check();
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (score1 !== 4'd1) bad++;
        end
        check_int("no_double_count", bad, 0);
        push("hold_exit_no_score", 1, 1, 0, 0, 0, 2'b00);
        check();
        push("second_goal_from_play", 2, 1, 1, 1, 0, 2'b00);
        step();
        check();
        ball(320, 240, 4);
        measure_hold(hi, gp_cnt);

        // Y window and X boundaries
        ball(18, 150, 4);
        push("above_mouth", 2, 1, 0, 0, 0, 2'b00);
        step();
        check();
        ball(18, 281, 4);
        push("below_mouth", 2, 1, 0, 0, 0, 2'b00);
        step();
        check();
        ball(27, 240, 4);
        push("left_edge_miss", 2, 1, 0, 0, 0, 2'b00);
        step();
        check();
        ball(3, 240, 4);
        push("left_underflow", 2, 2, 1, 1, 0, 2'b00);
        step();
        check();
        ball(320, 240, 4);
        measure_hold(hi, gp_cnt);
        ball(26, 200, 4);
        push("left_edge_top", 2, 3, 1, 1, 0, 2'b00);
        step();
        check();
        ball(320, 240, 4);
        measure_hold(hi, gp_cnt);
        ball(1000, 280, 30);
        push("right_no_wrap", 3, 3, 1, 1, 0, 2'b00);
        step();
        check();
        ball(320, 240, 4);
        measure_hold(hi, gp_cnt);
        ball(20, 240, 600);
        push("both_goals", 3, 3, 0, 0, 0, 2'b00);
        step();
        check();

        // Finish the match for player 1
        ball(614, 240, 4);
        push("right_goal_4", 4, 3, 1, 1, 0, 2'b00);
        step();
        check();
        ball(320, 240, 4);
        measure_hold(hi, gp_cnt);
        ball(614, 240, 4);
        push("winning_goal", 5, 3, 1, 1, 1, 2'b01);
        step();
        check();
        ball(18, 240, 4);
        for (int i = 0; i < 10; i++) step();
        push("over_holds", 5, 3, 1, 0, 1, 2'b01);
        check();

        startGame = 1'b1;
        push("start_game", 0, 0, 1, 0, 0, 2'b00);
        step();
        check();
        startGame = 1'b0;
        ball(320, 240, 4);
        measure_hold(hi, gp_cnt);
        check_int("hold_len_start", hi, 120);

        // startGame wins over a simultaneous goal
        ball(18, 240, 4);
        startGame = 1'b1;
        push("start_vs_goal", 0, 0, 1, 0, 0, 2'b00);
        step();
        check();
        startGame = 1'b0;
        ball(320, 240, 4);
        measure_hold(hi, gp_cnt);
        check_int("hold_len_start2", hi, 120);

        // Asynchronous reset in the middle of a hold
        ball(18, 240, 4);
        push("goal_before_reset", 0, 1, 1, 1, 0, 2'b00);
        step();
        check();
        ball(320, 240, 4);
        for (int i = 0; i < 69; i++) step();
        push("mid_hold", 0, 1, 1, 0, 0, 2'b00);
        check();
        #2 Reset = 1'b1;
        #1;
        push("async_reset", 0, 0, 0, 0, 0, 2'b00);
        check();
        #1 Reset = 1'b0;
        ball(18, 240, 4);
        push("goal_after_reset", 0, 1, 1, 1, 0, 2'b00);
        step();
        check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
